btn_uart_send: RTL and testbench
================================

// Module: btn_uart_send
// PURPOSE
//  Upstream sender for the LED-toggle UART link: debounces a push-button, and on each press
//  transmits one 8N1 frame carrying command byte CMD (0x01) at 115200 bit/s from a 27 MHz clock.
//  o_tx drives the serial line consumed by the LED receiver on the far board.
//  A single-deep pending flag makes a press during an active frame send one more frame afterwards.
// PARAMETERS
//  D          234      clock cycles per bit, round(27 MHz / 115200)
//  L          8        width of bit-timing counter (holds D-1)
//  CMD        8'h01    byte sent per press
//  DEBOUNCE   270000   cycles the synchronized button must be stable to be accepted (~10 ms)
//  DB_W       19       width of debounce counter (holds DEBOUNCE-1)
//  BTN_LOW    1        1: button is active-low (pressed = 0); 0: active-high
// PORTS
//  i_clk     in   1  system clock, 27 MHz
//  i_rst_n   in   1  reset, synchronous, active-low
//  i_btn     in   1  raw asynchronous push-button level
//  o_tx      out  1  UART serial output, idle high
//  o_busy    out  1  high while a frame (start..stop) is on the line
//  o_press   out  1  one-cycle pulse per accepted press (debug / LED)
// BEHAVIOUR
//  Reset (i_rst_n=0 at rising edge): o_tx=1, o_busy=0, o_press=0, state=IDLE, pending=0,
//   all counters=0, debounced level=released. Applies mid-frame too: line returns high on the
//   next edge, the partial frame is abandoned, no resend.
//  Input: 2-flop synchronizer on i_btn; polarity normalized by BTN_LOW to pressed=1.
//  Debounce: if sync != stable, cnt++; at cnt==DEBOUNCE-1, stable<=sync and cnt<=0;
//   if sync==stable, cnt<=0. Glitches shorter than DEBOUNCE cycles are never accepted.
//  Press event: stable 0->1 transition -> o_press=1 for exactly one cycle; release is ignored.
//  TX FSM (bit counter r_wait 0..D-1, bit index r_cnt 0..7):
//   IDLE : o_tx=1. If press or pending: load shift reg with CMD, clear pending, go START.
//   START: o_tx=0 for D cycles -> DATA, r_cnt=0.
//   DATA : o_tx=shift[0], LSB first; every D cycles shift right, r_cnt++; after bit 7 -> STOP.
//   STOP : o_tx=1 for D cycles -> IDLE.
//  o_busy=1 exactly in START/DATA/STOP. Frame = 10*D = 2340 cycles; every bit exactly D cycles.
//  Latency: o_press high in cycle N (IDLE) -> o_tx low from cycle N+1.
//  Press while busy: pending<=1; further presses while pending collapse (max one extra frame).
//  Press in the same cycle STOP ends: treated as pending; next frame starts after one IDLE cycle.
//  Back-to-back frames therefore have >= 1 idle-high cycle plus the full D-cycle stop bit.
//  Counters never wrap: r_wait is reset at D-1, r_cnt at 7, debounce cnt at DEBOUNCE-1.
// STRUCTURE
//  Shared include uart_params.vh: D, L, frame constants (start=0, stop=1, 8 data bits),
//   command codes (CMD_TOGGLE=8'h01); the LED receiver uses the same file.
//  Sub-module btn_debounce (synchronizer + debounce + press pulse, params DEBOUNCE/DB_W/BTN_LOW);
//   TX FSM stays in btn_uart_send.
// TESTING  (bench may override DEBOUNCE=16 for speed; D=234 kept)
//  Reset: hold i_rst_n=0 3 cycles -> o_tx=1, o_busy=0, o_press=0 throughout.
//  Clean press held 40 cycles -> one o_press pulse; o_tx shows 0,1,0,0,0,0,0,0,0,1 each 234
//   cycles; bench UART model decodes 0x01, no framing error.
//  Bounce: 10 toggles of 5 cycles each then stable press -> exactly one press, one frame.
//  Press during DATA bit 3, then two more presses -> exactly two frames total, second starts
//   one idle cycle after first stop bit ends.
//  Reset asserted mid-DATA -> o_tx=1, o_busy=0 next edge; no frame follows release of reset.
//  Loopback: o_tx into LED receiver, two presses -> receiver LED toggles on then off, no error.

Source files
------------

// File: rtl/btn_uart_send_pkg.sv
// Shared constants for the LED-toggle UART link: bit timing, frame bits, command codes
// and the sender FSM state type.
package btn_uart_send_pkg;

    localparam int unsigned UART_D     = 234;   // round(27 MHz / 115200)
    localparam int unsigned UART_L     = 8;     // holds UART_D-1
    localparam int unsigned DATA_BITS  = 8;
    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;
    localparam logic [7:0]  CMD_TOGGLE = 8'h01;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-flop synchronizer, polarity normalisation, counter debounce
// and a one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int unsigned DEBOUNCE = 270000,
    parameter int unsigned DB_W     = 19,
    parameter bit          BTN_LOW  = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);

    logic            sync1_q, sync2_q;
    logic            btn_n;
    logic            stable_q, stable_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            press_q;

    // Normalised so that 1 always means pressed.
    assign btn_n   = sync2_q ^ BTN_LOW;
    assign o_press = press_q;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (btn_n != stable_q) begin
            if (cnt_q == DB_W'(DEBOUNCE - 1)) begin
                stable_d = btn_n;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            // Synchronizer starts at the released raw level so reset never looks like a press.
            sync1_q  <= BTN_LOW;
            sync2_q  <= BTN_LOW;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= i_btn;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= stable_d & ~stable_q;
        end
    end

endmodule

// File: rtl/btn_uart_send.sv
// Button-triggered UART sender: each accepted press transmits one 8N1 frame of CMD,
// with a single-deep pending flag for presses that arrive while a frame is on the line.
module btn_uart_send
    import btn_uart_send_pkg::*;
#(
    parameter int unsigned D        = UART_D,
    parameter int unsigned L        = UART_L,
    parameter logic [7:0]  CMD      = CMD_TOGGLE,
    parameter int unsigned DEBOUNCE = 270000,
    parameter int unsigned DB_W     = 19,
    parameter bit          BTN_LOW  = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_tx,
    output logic o_busy,
    output logic o_press
);

    tx_state_e  state_q, state_d;
    logic [L-1:0] wait_q, wait_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       pending_q, pending_d;
    logic       press;
    logic       bit_done;

    btn_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .DB_W     (DB_W),
        .BTN_LOW  (BTN_LOW)
    ) u_debounce (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn),
        .o_press (press)
    );

    assign o_press  = press;
    assign bit_done = (wait_q == L'(D - 1));

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        pending_d = pending_q;
        o_tx      = STOP_BIT;
        o_busy    = 1'b1;

        // Presses during a frame collapse into one extra frame.
        if (press && state_q != StIdle) begin
            pending_d = 1'b1;
        end
        if (state_q != StIdle) begin
            wait_d = bit_done ? '0 : wait_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                o_busy = 1'b0;
                if (press || pending_q) begin
                    shift_d   = CMD;
                    pending_d = 1'b0;
                    wait_d    = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                o_tx = START_BIT;
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                o_tx = shift_q[0];
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == 3'(DATA_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = StStop;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StStop: begin
                o_tx = STOP_BIT;
                if (bit_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_btn_uart_send.sv
// Bench for btn_uart_send: randomised button stimulus, a cycle-level UART line decoder
// and a toggling-LED receiver model.
module tb_btn_uart_send;

    localparam int          D   = 234;
    localparam int          DEB = 16;
    localparam logic [7:0]  CMD = 8'h01;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic btn   = 1'b1;
    logic tx, busy, press;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   press_cnt = 0;
    int   press_cyc = 0;
    int   starts = 0;
    int   frames = 0;
    int   last_start = 0;
    int   start_q[$];
    int   idle_q[$];
    logic led = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    btn_uart_send #(
        .DEBOUNCE (DEB),
        .DB_W     (19)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn),
        .o_tx    (tx),
        .o_busy  (busy),
        .o_press (press)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int hold, output int set_c);
        btn   = 1'b0;
        set_c = cyc;
        step(hold);
        btn   = 1'b1;
    endtask

    // Alternating short glitches, each shorter than the debounce window.
    task automatic bounce();
        for (int i = 0; i < 10; i++) begin
            btn = (i % 2 == 0) ? 1'b0 : 1'b1;
            step($urandom_range(1, 12));
        end
        btn = 1'b1;
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (frames < target && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, frames >= target, 1);
    endtask

    // Press pulse monitor.
    initial begin : press_mon
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (prev === 1'b1) chk("press_one_cycle", press, 0);
            if (press === 1'b1 && prev !== 1'b1) begin
                press_cnt++;
                press_cyc = cyc;
            end
            prev = press;
        end
    end

    // Line decoder: every one of the 10 bits must hold its value for exactly D cycles.
    initial begin : uart_mon
        logic [9:0] exp_bits;
        logic [9:0] rx_bits;
        logic       bad;
        logic       abort;
        exp_bits = {1'b1, CMD, 1'b0};
        rx_bits  = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                starts++;
                last_start = cyc;
                start_q.push_back(cyc);
                abort = 1'b0;
                for (int k = 0; k < 10 && !abort; k++) begin
                    bad = 1'b0;
                    for (int j = 0; j < D && !abort; j++) begin
                        if (k != 0 || j != 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            abort = 1'b1;
                        end else begin
                            if (tx !== exp_bits[k] || busy !== 1'b1) bad = 1'b1;
                            if (j == D / 2) rx_bits[k] = tx;
                        end
                    end
                    if (!abort) chk($sformatf("frame_bit%0d_bad", k), bad, 0);
                end
                if (!abort) begin
                    chk("rx_byte", rx_bits[8:1], CMD);
                    chk("rx_framing", {rx_bits[9], rx_bits[0]}, 2'b10);
                    @(negedge clk);
                    if (rst_n === 1'b1) chk("idle_after_stop", {busy, tx}, 2'b01);
                    idle_q.push_back(cyc);
                    frames++;
                    if (rx_bits[8:1] == CMD && rx_bits[9] && !rx_bits[0]) led = ~led;
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1);
    end

    initial begin : stim
        int   p0, f0, s0, set_c;
        logic led_exp;
        led_exp = 1'b0;

        rst_n = 1'b0;
        btn   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("reset_tx", tx, 1);
            chk("reset_busy", busy, 0);
            chk("reset_press", press, 0);
        end
        rst_n = 1'b1;
        step(40);

        // Clean press
        push(40, set_c);
        wait_frames(1, 4000, "clean_frame_done");
        chk("clean_presses", press_cnt, 1);
        chk("clean_frames", frames, 1);
        chk("clean_press_latency", (press_cyc - set_c >= DEB) && (press_cyc - set_c <= DEB + 4), 1);
        chk("clean_press_to_tx", last_start - press_cyc, 1);
        led_exp = ~led_exp;
        chk("clean_led", led, led_exp);
        step(50);

        // Randomised bounce then stable press
        for (int r = 0; r < 3; r++) begin
            p0 = press_cnt;
            f0 = frames;
            step($urandom_range(20, 200));
            bounce();
            push($urandom_range(40, 80), set_c);
            wait_frames(f0 + 1, 4000, "bounce_frame_done");
            step(100);
            chk("bounce_presses", press_cnt - p0, 1);
            chk("bounce_frames", frames - f0, 1);
            chk("bounce_press_latency",
                (press_cyc - set_c >= DEB) && (press_cyc - set_c <= DEB + 4), 1);
            chk("bounce_press_to_tx", last_start - press_cyc, 1);
            led_exp = ~led_exp;
            chk("bounce_led", led, led_exp);
        end

        // Presses during DATA bit 3 collapse into one extra frame
        p0 = press_cnt;
        f0 = frames;
        s0 = start_q.size();
        push(40, set_c);
        chk("pend_first_started", start_q.size() - s0, 1);
        step(last_start + 4 * D + 20 - cyc);
        push(40, set_c);
        step(60);
        push(40, set_c);
        wait_frames(f0 + 2, 6000, "pend_frames_done");
        step(3000);
        chk("pend_presses", press_cnt - p0, 3);
        chk("pend_frames", frames - f0, 2);
        chk("pend_starts", start_q.size() - s0, 2);
        if (start_q.size() >= s0 + 2 && idle_q.size() >= f0 + 1)
            chk("pend_gap", start_q[s0 + 1] - idle_q[f0], 1);
        chk("pend_led", led, led_exp);

        // Reset in the middle of DATA abandons the frame
        f0 = frames;
        s0 = starts;
        push(40, set_c);
        step(last_start + 3 * D + 100 - cyc);
        chk("midrst_pre_busy", busy, 1);
        rst_n = 1'b0;
        step(1);
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        step(2);
        rst_n = 1'b1;
        step(3000);
        chk("midrst_no_frame", frames - f0, 0);
        chk("midrst_no_restart", starts - s0, 1);
        chk("midrst_idle", {busy, tx}, 2'b01);
        chk("final_led", led, led_exp);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
